fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined miniRV core, directly upstream of the decode stage that holds the instruction decoder. It owns the program counter, drives the instruction ROM address, and registers {pc, pc+4, instruction, valid} into the IF/ID pipeline register that decode consumes. It obeys stall requests from hazard detection and redirects from the branch/jump resolution logic in EX. It also keeps two free-running performance counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- cpu_clk  in  1  core clock; all state updates on rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents (load-use hazard).
- redirect  in  1  taken branch or jump resolved in EX; discard wrong-path fetch.
- redirect_pc  in  32  target address, valid when redirect=1.
- inst_addr  out  32  IROM address; equals current PC (combinational from PC register).
- inst_in  in  32  IROM read data for inst_addr, same cycle (asynchronous ROM).
- id_pc  out  32  PC of the instruction in IF/ID.
- id_pc4  out  32  id_pc + 4, for the PC+4 write-back path.
- id_inst  out  32  instruction in IF/ID; 32'h0000_0000 when bubble.
- id_valid  out  1  IF/ID holds a real instruction.
- fetch_cnt  out  32  count of instructions accepted into IF/ID.
- flush_cnt  out  32  count of redirects taken.

## Operation
- State: pc (32), IF/ID register {id_pc, id_pc4, id_inst, id_valid}, fetch_cnt, flush_cnt.
- Each rising edge is resolved by priority: redirect > stall > normal advance.
- Normal advance (redirect=0, stall=0):
  - pc <= pc + 4.
  - id_pc <= pc, id_pc4 <= pc + 4, id_inst <= inst_in, id_valid <= 1.
  - fetch_cnt <= fetch_cnt + 1.
- Stall (redirect=0, stall=1): pc, IF/ID and both counters hold.
- Redirect (redirect=1, stall don't-care):
  - pc <= {redirect_pc[31:2], 2'b00}; the low bits are always forced to zero.
  - IF/ID becomes a bubble: id_inst <= 0, id_valid <= 0, id_pc <= 0, id_pc4 <= 0.
  - flush_cnt <= flush_cnt + 1. fetch_cnt holds.
- Bubble encoding: opcode 7'b0000000 decodes in decode with register-file write and RAM write disabled, so a bubble has no architectural effect.
- Arithmetic: pc + 4 and both counters wrap modulo 2^32 with no saturation or flag.
  - pc = 32'hFFFF_FFFC advances to 32'h0000_0000.
  - A counter at 32'hFFFF_FFFF increments to 0.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-stall or mid-redirect):
  - pc = RESET_PC, so inst_addr = RESET_PC.
  - id_pc = 0, id_pc4 = 0, id_inst = 0, id_valid = 0.
  - fetch_cnt = 0, flush_cnt = 0.
- First edge after reset release with stall=0, redirect=0: IF/ID captures the instruction at RESET_PC with id_valid=1, and pc becomes RESET_PC+4.
- Latency: one cycle from inst_addr presentation to id_inst.
- inst_addr changes only on a clock edge or reset; it has no combinational path from stall, redirect or redirect_pc.
- Redirect penalty: the redirect target appears on inst_addr the cycle after redirect is asserted, and in IF/ID one further cycle later.
- Consecutive redirect cycles: each one reloads pc, bubbles IF/ID and increments flush_cnt.
- A stall held for N cycles freezes every output for N cycles. Release resumes with no lost or duplicated instruction.

## Test plan
- Reset then free-run 4 cycles, RESET_PC=0, IROM word[i]=i+1: id_inst sequence 1,2,3,4; id_pc 0,4,8,12; id_pc4 4,8,12,16; fetch_cnt=4.
- Stall for 3 cycles after the second fetch: outputs frozen at id_pc=4 and pc=8 for 3 cycles; the next edge gives id_pc=8, id_inst=3, with no skip or duplicate.
- Redirect to 32'h0000_0103 together with stall=1: inst_addr=32'h100 next cycle; id_valid=0 and id_inst=0 that cycle; flush_cnt=1; fetch_cnt unchanged; the following edge gives id_pc=32'h100.
- Two back-to-back redirects (targets 0x40, then 0x80): flush_cnt increments by 2, id_valid stays 0 for 2 cycles, then id_pc=0x80.
- Wrap: redirect to 32'hFFFF_FFFC, then advance: id_pc=32'hFFFF_FFFC with id_pc4=0, and inst_addr=0.
- Assert cpu_rst asynchronously mid-stall (between edges): all outputs return to reset values immediately, without waiting for a clock edge; after release the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the IROM and fills the IF/ID register.
// Handles stall and EX redirects, and keeps fetch/flush performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Priority: redirect > stall > advance. A redirect squashes the wrong-path fetch.
  always_comb begin
    pc_d        = pc_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      id_pc_d     = 32'd0;
      id_pc4_d    = 32'd0;
      id_inst_d   = 32'd0;
      id_valid_d  = 1'b0;
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (!stall) begin
      pc_d        = pc_plus4;
      id_pc_d     = pc_q;
      id_pc4_d    = pc_plus4;
      id_inst_d   = inst_in;
      id_valid_d  = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pc_q        <= RESET_PC;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      id_inst_q   <= 32'd0;
      id_valid_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign inst_addr = pc_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;
  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; IROM model returns (addr >> 2) + 1.
module tb_fetch_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_addr   (inst_addr),
    .inst_in     (inst_in),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  assign inst_in = (inst_addr >> 2) + 32'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " inst_addr"}, inst_addr, 32'h0);
    check({tag, " id_pc"}, id_pc, 32'h0);
    check({tag, " id_pc4"}, id_pc4, 32'h0);
    check({tag, " id_inst"}, id_inst, 32'h0);
    check({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, " fetch_cnt"}, fetch_cnt, 32'h0);
    check({tag, " flush_cnt"}, flush_cnt, 32'h0);
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    #3;
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
  endtask

  initial begin
    cpu_rst     = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #2;
    check_reset_state("reset");
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // Free run: four sequential fetches.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("run id_inst", id_inst, 32'(i + 1));
      check("run id_pc", id_pc, 32'(4 * i));
      check("run id_pc4", id_pc4, 32'(4 * i + 4));
      check("run id_valid", {31'd0, id_valid}, 32'd1);
    end
    check("run fetch_cnt", fetch_cnt, 32'd4);
    check("run inst_addr", inst_addr, 32'd16);

    // Stall 3 cycles after the second fetch.
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall id_pc", id_pc, 32'd4);
      check("stall id_inst", id_inst, 32'd2);
      check("stall inst_addr", inst_addr, 32'd8);
      check("stall fetch_cnt", fetch_cnt, 32'd2);
    end
    stall = 1'b0;
    tick();
    check("unstall id_pc", id_pc, 32'd8);
    check("unstall id_inst", id_inst, 32'd3);
    check("unstall fetch_cnt", fetch_cnt, 32'd3);

    // Redirect with stall also asserted; low bits of target forced to zero.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    stall       = 1'b1;
    #1;
    check("redir no comb path", inst_addr, 32'd12);
    tick();
    check("redir inst_addr", inst_addr, 32'h100);
    check("redir id_valid", {31'd0, id_valid}, 32'd0);
    check("redir id_inst", id_inst, 32'h0);
    check("redir id_pc", id_pc, 32'h0);
    check("redir flush_cnt", flush_cnt, 32'd1);
    check("redir fetch_cnt", fetch_cnt, 32'd3);
    redirect = 1'b0;
    stall    = 1'b0;
    tick();
    check("post redir id_pc", id_pc, 32'h100);
    check("post redir id_inst", id_inst, 32'h41);
    check("post redir fetch_cnt", fetch_cnt, 32'd4);

    // Back-to-back redirects.
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    check("b2b1 id_valid", {31'd0, id_valid}, 32'd0);
    check("b2b1 inst_addr", inst_addr, 32'h40);
    redirect_pc = 32'h80;
    tick();
    check("b2b2 id_valid", {31'd0, id_valid}, 32'd0);
    check("b2b2 inst_addr", inst_addr, 32'h80);
    check("b2b flush_cnt", flush_cnt, 32'd3);
    redirect = 1'b0;
    tick();
    check("b2b id_pc", id_pc, 32'h80);
    check("b2b id_inst", id_inst, 32'h21);
    check("b2b id_valid", {31'd0, id_valid}, 32'd1);

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("wrap inst_addr pre", inst_addr, 32'hFFFF_FFFC);
    check("wrap flush_cnt", flush_cnt, 32'd4);
    redirect = 1'b0;
    tick();
    check("wrap id_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap id_pc4", id_pc4, 32'h0);
    check("wrap id_inst", id_inst, 32'h4000_0000);
    check("wrap inst_addr", inst_addr, 32'h0);
    check("wrap fetch_cnt", fetch_cnt, 32'd6);

    // Asynchronous reset between edges while stalled.
    stall = 1'b1;
    tick();
    #2;
    cpu_rst = 1'b1;
    #1;
    check_reset_state("async rst");
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    stall   = 1'b0;
    tick();
    check("restart id_pc", id_pc, 32'h0);
    check("restart id_inst", id_inst, 32'd1);
    check("restart id_valid", {31'd0, id_valid}, 32'd1);
    check("restart inst_addr", inst_addr, 32'd4);
    check("restart fetch_cnt", fetch_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
